// File: rtl/nn_accel_pkg.sv
// Shared types and defaults for the MNIST accelerator output stage.
package nn_accel_pkg;
   localparam int NUM_CLASSES_DEF = 10;
   localparam int SCORE_W_DEF     = 16;
   localparam logic [3:0] BCD_ERROR = 4'hF;

   typedef enum logic [1:0] {ARG_IDLE, ARG_COLLECT, ARG_DONE} argmax_state_e;
endpackage

// File: rtl/argmax_cmp_update.sv
// Combinational running-max update: signed compare, ties keep the lower index.
// Second-best tracking exists only when ARGMAX_MARGIN_EN is defined.
module argmax_cmp_update #(
   parameter int SCORE_W = 16,
   parameter int IDX_W   = 5
) (
   input  logic signed [SCORE_W-1:0] best,
   input  logic        [IDX_W-1:0]   best_idx,
`ifdef ARGMAX_MARGIN_EN
   input  logic signed [SCORE_W-1:0] second,
   output logic signed [SCORE_W-1:0] nxt_second,
`endif
   input  logic signed [SCORE_W-1:0] score,
   input  logic        [IDX_W-1:0]   idx,
   output logic signed [SCORE_W-1:0] nxt_best,
   output logic        [IDX_W-1:0]   nxt_best_idx
);
   always_comb begin
      nxt_best     = best;
      nxt_best_idx = best_idx;
`ifdef ARGMAX_MARGIN_EN
      nxt_second   = second;
`endif
      if (idx == '0) begin
         nxt_best     = score;
         nxt_best_idx = '0;
      end else if (score > best) begin
         nxt_best     = score;
         nxt_best_idx = idx;
`ifdef ARGMAX_MARGIN_EN
         nxt_second   = best;
`endif
      end
`ifdef ARGMAX_MARGIN_EN
      // index 1 always seeds second when it does not win
      else if (idx == IDX_W'(1) || score > second) begin
         nxt_second = score;
      end
`endif
   end
endmodule

// File: rtl/nn_output_argmax.sv
// Output-layer argmax: streams NUM_CLASSES signed scores, reports BCD winner.
// Define ARGMAX_MARGIN_EN to report the top1-minus-top2 margin.
module nn_output_argmax
   import nn_accel_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int SCORE_W     = SCORE_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      score_valid,
   output logic                      score_ready,
   input  logic signed [SCORE_W-1:0] score_data,
   input  logic                      score_last,
   output logic                      busy,
   output logic                      class_valid,
   output logic [3:0]                class_bcd,
   output logic                      frame_error,
   output logic [SCORE_W:0]          margin
);
   localparam int CW = $clog2(NUM_CLASSES) + 1;

   argmax_state_e state, state_nxt;
   logic [CW-1:0] cnt, best_idx, nb_idx;
   logic signed [SCORE_W-1:0] best, nb;
   logic accept, at_last, frame_end, frame_err;

   assign accept    = score_valid & score_ready;
   assign at_last   = (cnt == CW'(NUM_CLASSES - 1));
   assign frame_end = score_last | at_last;
   // early last or missing last on the final index are both framing errors
   assign frame_err = score_last ^ at_last;

`ifdef ARGMAX_MARGIN_EN
   logic signed [SCORE_W-1:0] second, ns;
   argmax_cmp_update #(.SCORE_W(SCORE_W), .IDX_W(CW)) u_cmp (
      .best(best), .best_idx(best_idx), .second(second), .nxt_second(ns),
      .score(score_data), .idx(cnt), .nxt_best(nb), .nxt_best_idx(nb_idx)
   );
`else
   argmax_cmp_update #(.SCORE_W(SCORE_W), .IDX_W(CW)) u_cmp (
      .best(best), .best_idx(best_idx),
      .score(score_data), .idx(cnt), .nxt_best(nb), .nxt_best_idx(nb_idx)
   );
   assign margin = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ARG_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARG_IDLE:    if (start) state_nxt = ARG_COLLECT;
         ARG_COLLECT: if (!start && accept && frame_end) state_nxt = ARG_DONE;
         ARG_DONE:    if (start) state_nxt = ARG_COLLECT;
         default:     state_nxt = ARG_IDLE;
      endcase
   end

   always_comb begin
      busy        = (state == ARG_COLLECT);
      score_ready = (state == ARG_COLLECT) && !start;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         best        <= '0;
         best_idx    <= '0;
         class_valid <= 1'b0;
         class_bcd   <= 4'd0;
         frame_error <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
         second      <= '0;
         margin      <= '0;
`endif
      end else if (start) begin
         // class_bcd deliberately keeps the previous result
         cnt         <= '0;
         best        <= '0;
         best_idx    <= '0;
         class_valid <= 1'b0;
         frame_error <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
         second      <= '0;
         margin      <= '0;
`endif
      end else if (accept) begin
         cnt      <= cnt + 1'b1;
         best     <= nb;
         best_idx <= nb_idx;
`ifdef ARGMAX_MARGIN_EN
         second   <= ns;
`endif
         if (frame_end) begin
            class_valid <= 1'b1;
            frame_error <= frame_err;
            class_bcd   <= frame_err ? BCD_ERROR : 4'(nb_idx);
`ifdef ARGMAX_MARGIN_EN
            margin      <= frame_err ? '0 : ({nb[SCORE_W-1], nb} - {ns[SCORE_W-1], ns});
`endif
         end
      end
   end
endmodule

// File: tb/tb_nn_output_argmax.sv
// Self-checking bench: frame-level argmax model compared every cycle, plus literal pins.
module tb_nn_output_argmax;
   localparam int NC = 10;
   localparam int SW = 16;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, score_valid = 1'b0, score_last = 1'b0;
   logic signed [SW-1:0] score_data = '0;
   logic score_ready, busy, class_valid, frame_error;
   logic [3:0] class_bcd;
   logic [SW:0] margin;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   nn_output_argmax #(.NUM_CLASSES(NC), .SCORE_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .score_valid(score_valid),
      .score_ready(score_ready), .score_data(score_data), .score_last(score_last),
      .busy(busy), .class_valid(class_valid), .class_bcd(class_bcd),
      .frame_error(frame_error), .margin(margin)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Frame-level model: collect accepted scores, resolve argmax when the frame ends.
   bit m_collect = 0, m_cv = 0, m_fe = 0;
   logic [3:0] m_bcd = 4'd0;
   int m_margin = 0;
   int q[$];

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_collect = 0; m_cv = 0; m_fe = 0; m_bcd = 4'd0; m_margin = 0;
         q.delete();
      end else if (start) begin
         m_collect = 1; m_cv = 0; m_fe = 0; m_margin = 0;
         q.delete();
      end else if (m_collect && score_valid) begin
         q.push_back(int'(score_data));
         if (score_last || q.size() == NC) begin
            m_collect = 0;
            m_cv = 1;
            if (!score_last || q.size() != NC) begin
               m_fe = 1; m_bcd = 4'hF; m_margin = 0;
            end else begin
               int w, s;
               w = 0;
               for (int i = 1; i < NC; i++) if (q[i] > q[w]) w = i;
               s = -(1 << 30);
               for (int i = 0; i < NC; i++) if (i != w && q[i] > s) s = q[i];
               m_fe = 0;
               m_bcd = 4'(w);
`ifdef ARGMAX_MARGIN_EN
               m_margin = q[w] - s;
`else
               m_margin = 0;
`endif
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("score_ready", 32'(score_ready), 32'(m_collect && !start));
      chk("busy", 32'(busy), 32'(m_collect));
      chk("class_valid", 32'(class_valid), 32'(m_cv));
      chk("class_bcd", 32'(class_bcd), 32'(m_bcd));
      chk("frame_error", 32'(frame_error), 32'(m_fe));
      chk("margin", 32'(margin), 32'(m_margin));
   end

   task automatic cyc(input bit v, input int d, input bit l, input bit s);
      score_valid = v; score_data = SW'(d); score_last = l; start = s;
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input int sc[NC], input int last_at, input bit do_start, input bit gaps);
      if (do_start) cyc(0, 0, 0, 1);
      for (int i = 0; i < NC; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) cyc(0, int'($urandom_range(0, 200)), 0, 0);
         cyc(1, sc[i], i == last_at, 0);
         if (i == last_at || i == NC - 1) begin
            chk("latency_cv", 32'(class_valid), 32'd1);
            break;
         end
      end
      cyc(0, 0, 0, 0);
   endtask

   int f1[NC]   = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};
   int ftie[NC] = '{0, 0, 0, 9, 0, 0, 0, 9, 0, 0};
   int fneg[NC] = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
   int fgap[NC] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
   int fab[NC]  = '{3, 1, 4, 1, 5, 50, 2, 6, 5, 3};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(score_ready), 32'd0);
      chk("rst_bcd", 32'(class_bcd), 32'd0);
      rst_n = 1'b1;
      cyc(1, 77, 1, 0);                       // offered in IDLE: ignored
      chk("idle_cv", 32'(class_valid), 32'd0);

      frame(f1, NC - 1, 1, 0);
      chk("f1_bcd", 32'(class_bcd), 32'd2);
      chk("f1_fe", 32'(frame_error), 32'd0);
`ifdef ARGMAX_MARGIN_EN
      chk("f1_margin", 32'(margin), 32'd1);
`else
      chk("f1_margin", 32'(margin), 32'd0);
`endif
      repeat (3) cyc(1, 999, 1, 0);           // offered in DONE: ignored
      chk("done_bcd", 32'(class_bcd), 32'd2);
      cyc(0, 0, 0, 1);                        // start in DONE
      chk("restart_cv", 32'(class_valid), 32'd0);
      chk("restart_bcd_held", 32'(class_bcd), 32'd2);

      frame(ftie, NC - 1, 0, 0);
      chk("tie_bcd", 32'(class_bcd), 32'd3);
      frame(fneg, NC - 1, 1, 0);
      chk("neg_bcd", 32'(class_bcd), 32'd0);
      chk("neg_margin", 32'(margin), 32'd0);
      frame(fgap, NC - 1, 1, 1);
      chk("gap_bcd", 32'(class_bcd), 32'd9);

      frame(f1, 3, 1, 0);                     // early last
      chk("early_bcd", 32'(class_bcd), 32'hF);
      chk("early_fe", 32'(frame_error), 32'd1);
      chk("early_ready", 32'(score_ready), 32'd0);
      repeat (2) cyc(1, 5, 0, 0);
      chk("early_cv", 32'(class_valid), 32'd1);

      frame(f1, -1, 1, 0);                    // missing last
      chk("nolast_bcd", 32'(class_bcd), 32'hF);
      chk("nolast_fe", 32'(frame_error), 32'd1);
      chk("nolast_margin", 32'(margin), 32'd0);

      cyc(0, 0, 0, 1);
      for (int i = 0; i < 6; i++) cyc(1, 1000, 0, 0);
      cyc(1, 500, 0, 1);                      // abort with a beat offered
      frame(fab, NC - 1, 0, 0);
      chk("abort_bcd", 32'(class_bcd), 32'd5);
      chk("abort_fe", 32'(frame_error), 32'd0);

      cyc(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(1, 40, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(score_ready), 32'd0);
      chk("arst_bcd", 32'(class_bcd), 32'd0);
      chk("arst_cv", 32'(class_valid), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      frame(f1, NC - 1, 1, 0);
      chk("post_rst_bcd", 32'(class_bcd), 32'd2);
      chk("post_rst_cv", 32'(class_valid), 32'd1);

      cyc(0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
